// File: rtl/ext_mem_arb_pkg.sv
// rtl/ext_mem_arb_pkg.sv - shared types and widths for the external memory arbiter
package ext_mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int GID_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select starting just after the pointer
module rr_picker
  import ext_mem_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [GID_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [GID_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  // Walk pointer+1, pointer+2, ... with wrap; the first active request wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand[GID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - round-robin arbiter for the shared 8-bit external memory bus
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ext_mem_addr,
  output logic [DATA_W-1:0]         ext_mem_wdata,
  output logic                      ext_mem_data_oe,
  input  logic [DATA_W-1:0]         ext_mem_rdata,
  output logic                      ext_mem_cs,
  output logic                      ext_mem_read,
  output logic                      ext_mem_write,
  input  logic                      ext_mem_ready,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id
);

  localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT_CYCLES);
  localparam logic [GID_W-1:0] PTR_INIT = GID_W'(NUM_REQ - 1);

  state_t             r_state;
  logic [GID_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [7:0]         r_tcnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [GID_W-1:0]   w_idx;
  logic               w_any;
  logic [7:0]         w_tcnt_nxt;

  assign w_tcnt_nxt = r_tcnt + 8'd1;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Transaction FSM: grant in IDLE, hold latched bus values in ACCESS, one dead cycle in RECOVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_ptr           <= PTR_INIT;
      r_gnt           <= '0;
      r_tcnt          <= '0;
      req_ack         <= '0;
      req_err         <= '0;
      rdata           <= '0;
      ext_mem_addr    <= '0;
      ext_mem_wdata   <= '0;
      ext_mem_data_oe <= 1'b0;
      ext_mem_cs      <= 1'b0;
      ext_mem_read    <= 1'b0;
      ext_mem_write   <= 1'b0;
      busy            <= 1'b0;
      grant_id        <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            ext_mem_addr    <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            ext_mem_wdata   <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
            ext_mem_write   <= req_write[w_idx];
            ext_mem_read    <= ~req_write[w_idx];
            ext_mem_data_oe <= req_write[w_idx];
            ext_mem_cs      <= 1'b1;
            grant_id        <= w_idx;
            r_ptr           <= w_idx;
            r_gnt           <= w_gnt;
            r_tcnt          <= '0;
            busy            <= 1'b1;
            r_state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (ext_mem_ready || (w_tcnt_nxt == TO_LIM)) begin
            req_ack <= r_gnt;
            if (!ext_mem_ready) begin
              req_err <= r_gnt;
              rdata   <= '0;
            end else if (!ext_mem_write) begin
              rdata   <= ext_mem_rdata;
            end
            ext_mem_cs      <= 1'b0;
            ext_mem_read    <= 1'b0;
            ext_mem_write   <= 1'b0;
            ext_mem_data_oe <= 1'b0;
            r_state         <= ST_RECOVER;
          end else begin
            r_tcnt <= w_tcnt_nxt;
          end
        end
        ST_RECOVER: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - scoreboard bench for ext_mem_arbiter
module tb_ext_mem_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_write;
  logic [16*N-1:0] req_addr;
  logic [8*N-1:0]  req_wdata;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  req_err;
  logic [7:0]    rdata;
  logic [15:0]   ext_mem_addr;
  logic [7:0]    ext_mem_wdata;
  logic          ext_mem_data_oe;
  logic [7:0]    ext_mem_rdata;
  logic          ext_mem_cs;
  logic          ext_mem_read;
  logic          ext_mem_write;
  logic          ext_mem_ready;
  logic          busy;
  logic [1:0]    grant_id;

  ext_mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ack         (req_ack),
    .req_err         (req_err),
    .rdata           (rdata),
    .ext_mem_addr    (ext_mem_addr),
    .ext_mem_wdata   (ext_mem_wdata),
    .ext_mem_data_oe (ext_mem_data_oe),
    .ext_mem_rdata   (ext_mem_rdata),
    .ext_mem_cs      (ext_mem_cs),
    .ext_mem_read    (ext_mem_read),
    .ext_mem_write   (ext_mem_write),
    .ext_mem_ready   (ext_mem_ready),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] rd;
    bit         err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [0:65535];
  bit         ready_en;
  logic [7:0] last_rd;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: ready the cycle after cs is seen, on every such cycle.
  always @(posedge clk) begin
    if (ext_mem_cs && ready_en) begin
      ext_mem_ready <= 1'b1;
      if (ext_mem_write) mem[ext_mem_addr] <= ext_mem_wdata;
      else ext_mem_rdata <= mem[ext_mem_addr];
    end else begin
      ext_mem_ready <= 1'b0;
    end
  end

  // Completion monitor: every ack pops one expected transaction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (req_ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(req_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(req_ack), 32'(3'b001 << e.id));
        chk("ack_grant_id", 32'(grant_id), 32'(e.id));
        chk("ack_rdata", 32'(rdata), 32'(e.rd));
        chk("ack_err", 32'(req_err), e.err ? 32'(3'b001 << e.id) : 32'd0);
      end
    end else if (req_err != '0) begin
      chk("err_without_ack", 32'(req_err), 32'd0);
    end
  end

  task automatic issue(input int id, input bit wr, input logic [15:0] a, input logic [7:0] d);
    req_write[id]          = wr;
    req_addr[id*16 +: 16]  = a;
    req_wdata[id*8 +: 8]   = d;
    req_valid[id]          = 1'b1;
  endtask

  task automatic push(input int id, input logic [7:0] rd, input bit err);
    exp_t e;
    e.id = id; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int id);
    bit seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (req_ack[id]) seen = 1'b1;
    end
    req_valid[id] = 1'b0;
    if (!seen) chk("ack_wait", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 8'h00;
  endtask

  initial begin
    logic [3:0] cs_pat;
    logic [3:0] ack_pat;
    int n, last, ncs;
    bit done;

    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    ext_mem_ready = 1'b0; ext_mem_rdata = '0; ready_en = 1'b1; last_rd = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'h32; mem[16'h0100] = 8'h11; mem[16'h0200] = 8'h22;
    mem[16'h0300] = 8'h33; mem[16'h4000] = 8'h5C; mem[16'h2222] = 8'h77;
    mem[16'h3333] = 8'h99;

    #12;
    chk("rst_cs", 32'(ext_mem_cs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_addr", 32'(ext_mem_addr), 32'd0);
    chk("rst_oe", 32'(ext_mem_data_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read, requester 0: cs cycles 1-2, ack cycle 3, idle cycle 4.
    @(negedge clk);
    cs_pat = 4'b0011; ack_pat = 4'b0100;
    issue(0, 1'b0, 16'h8000, 8'h00);
    push(0, 8'h32, 1'b0);
    last_rd = 8'h32;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_cs_cycle", 32'(ext_mem_cs), 32'(cs_pat[k]));
      chk("rd_ack_cycle", 32'(req_ack[0]), 32'(ack_pat[k]));
      if (k == 0) chk("rd_strobe", 32'(ext_mem_read), 32'd1);
      if (k == 2) req_valid[0] = 1'b0;
    end
    chk("rd_busy_idle", 32'(busy), 32'd0);

    // Write, requester 1.
    issue(1, 1'b1, 16'h1234, 8'hA5);
    push(1, last_rd, 1'b0);
    @(negedge clk);
    chk("wr_write", 32'(ext_mem_write), 32'd1);
    chk("wr_read", 32'(ext_mem_read), 32'd0);
    chk("wr_oe", 32'(ext_mem_data_oe), 32'd1);
    chk("wr_wdata", 32'(ext_mem_wdata), 32'hA5);
    chk("wr_addr", 32'(ext_mem_addr), 32'h1234);
    wait_ack(1);
    @(negedge clk);
    chk("wr_mem", 32'(mem[16'h1234]), 32'hA5);
    chk("wr_single_ack", 32'(req_ack), 32'd0);

    // Fairness from reset: 0,1,2 repeated, acks 4 cycles apart.
    do_reset();
    req_addr = {16'h0300, 16'h0200, 16'h0100};
    req_write = '0;
    for (int t = 0; t < 9; t++) push(t % 3, mem[16'h0100 * ((t % 3) + 1)], 1'b0);
    last_rd = 8'h33;
    req_valid = 3'b111;
    n = 0; last = -1;
    for (int c = 0; c < 80 && n < 9; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        if (last >= 0) chk("fair_spacing", 32'(c - last), 32'd4);
        last = c;
        n++;
      end
    end
    req_valid = '0;
    chk("fair_count", 32'(n), 32'd9);

    // Timeout: ready held low, 16 ACCESS cycles then ack+err.
    @(negedge clk);
    ready_en = 1'b0;
    issue(0, 1'b0, 16'h4000, 8'h00);
    push(0, 8'h00, 1'b1);
    ncs = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (req_ack[0]) done = 1'b1;
      else if (ext_mem_cs) ncs++;
    end
    req_valid[0] = 1'b0;
    chk("to_acked", 32'(done), 32'd1);
    chk("to_access_cycles", 32'(ncs), 32'd16);
    ready_en = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 16'h4000, 8'h00);
    push(0, 8'h5C, 1'b0);
    wait_ack(0);

    // Reset in the first ACCESS cycle: bus drops at once, no ack.
    @(negedge clk);
    issue(0, 1'b0, 16'h8000, 8'h00);
    @(negedge clk);
    chk("mid_cs_before", 32'(ext_mem_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_after", 32'(ext_mem_cs), 32'd0);
    chk("mid_read_after", 32'(ext_mem_read), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2, 1'b0, 16'h2222, 8'h00);
    push(2, 8'h77, 1'b0);
    @(negedge clk);
    chk("mid_grant2", 32'(grant_id), 32'd2);
    wait_ack(2);

    // Latched address survives req_addr change; stale ready in RECOVER is ignored.
    @(negedge clk);
    issue(1, 1'b0, 16'h3333, 8'h00);
    push(1, 8'h99, 1'b0);
    @(negedge clk);
    req_addr[31:16] = 16'hFFFF;
    @(negedge clk);
    chk("latch_addr", 32'(ext_mem_addr), 32'h3333);
    @(negedge clk);
    chk("stale_ack", 32'(req_ack[1]), 32'd1);
    chk("stale_ready_seen", 32'(ext_mem_ready), 32'd1);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_extra_ack", 32'(req_ack), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
Shares the single 8-bit external memory bus (16-bit address, cs/read/write strobes, ready handshake) among NUM_REQ on-chip requesters. Requester 0 is the CPU load/store/fetch path, requester 1 is the MMU page-table walker (reads 0xE000-0xE0FF), and requester 2 is DMA/UART. It sits between these masters and the external memory pins inside microprocessor_system. It performs round-robin arbitration, one transaction at a time, with a ready timeout.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles to wait for ext_mem_ready before aborting (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until the matching req_ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  16*NUM_REQ  packed addresses; requester i uses bits [16i+15:16i]
req_wdata  in  8*NUM_REQ  packed write data
req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
req_err  out  NUM_REQ  one-cycle timeout pulse, coincident with req_ack
rdata  out  8  read data; valid in the req_ack cycle and held until the next capture
ext_mem_addr  out  16  external address
ext_mem_wdata  out  8  external write data (the top level tristates it onto ext_mem_data)
ext_mem_data_oe  out  1  write-data drive enable
ext_mem_rdata  in  8  external read data
ext_mem_cs  out  1  chip select
ext_mem_read  out  1  read strobe
ext_mem_write  out  1  write strobe
ext_mem_ready  in  1  memory ready
busy  out  1  high in any state other than IDLE
grant_id  out  2  index of the current or last granted requester

Behaviour:
- Reset (asynchronous, rst_n low) sets these values immediately:
  - state = IDLE
  - all outputs = 0: ext_mem_cs/read/write/data_oe, addr, wdata, rdata, req_ack, req_err, busy, grant_id
  - round-robin pointer = NUM_REQ-1, so requester 0 wins first
- Reset during ACCESS aborts the transaction silently: no ack, no err.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req_valid is high, pick the winner by searching from pointer+1 upward with wrap.
  - Latch the winner's addr/wdata/write, set grant_id, update pointer = winner, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Drive cs=1, read=~write, write=write, data_oe=write, from the latched values only.
  - Later changes on req_* do not affect the bus.
  - Timeout counter clears on entry and increments each cycle.
  - When ext_mem_ready is sampled high: for a read, capture rdata<=ext_mem_rdata; pulse req_ack[grant]; go to RECOVER.
  - When the counter reaches TIMEOUT_CYCLES first: pulse req_ack and req_err for the grant, set rdata<=0x00, go to RECOVER.
  - If ready and timeout coincide, ready wins (no err).
- RECOVER:
  - One cycle with cs/read/write/data_oe = 0, then IDLE.
  - Purpose: the memory asserts ready on every cycle cs is seen, so a stale ready arrives here; it is ignored.
- ext_mem_ready is ignored outside ACCESS.
- Latency with a ready-next-cycle memory (cycle 0 = IDLE sees req):
  - cycle 1: ACCESS, cs high
  - cycle 2: ready high
  - cycle 3: req_ack high, rdata valid, RECOVER
  - cycle 4: IDLE
  - Minimum occupancy is 4 cycles per transaction.
- A requester that keeps req_valid high after its ack issues a new request and competes again in IDLE.
- Round-robin guarantees service within NUM_REQ transactions of assertion.
- Address and data widths are fixed at 16/8; there is no arithmetic beyond the 8-bit saturating-free timeout counter, which never exceeds TIMEOUT_CYCLES.

Decomposition:
- Package ext_mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RECOVER}
  - ADDR_W = 16, DATA_W = 8
  - grant-id width constant
- Sub-module rr_picker: combinational round-robin select.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Read, requester 0: memory[0x8000]=0x32, req0 read 0x8000 → cs high exactly cycles 1-2, req_ack[0] in cycle 3, rdata=0x32, req_err=0.
- Write, requester 1: req1 writes 0xA5 to 0x1234 → write=1, read=0, data_oe=1 during ACCESS; memory[0x1234]=0xA5 afterwards; single ack pulse.
- Fairness: all three req_valid held continuously for 9 transactions → grant_id sequence 0,1,2,0,1,2,0,1,2; each ack one-hot, 4 cycles apart.
- Timeout: ready tied low, TIMEOUT_CYCLES=16 → req_ack and req_err for the requester after 16 ACCESS cycles, rdata=0x00; a following request with ready restored completes normally.
- Reset mid-transaction: rst_n low in the first ACCESS cycle of a read → cs/read drop in the same timestep, no ack; after release, req2 alone is granted with grant_id=2 and completes normally.
- Stale ready and latch: change req_addr to 0xFFFF during ACCESS → bus address stays at the latched value; the ready pulse in RECOVER produces no extra ack.
